// File: rtl/jtag_tap_driver.sv
// -----------------------------------------------------------------------------
// jtag_tap_driver
//
// FPGA-side JTAG initiator. Accepts high-level commands (TAP reset, IR scan,
// DR scan, idle clocks) on a valid/ready interface, generates the matching
// TCK/TMS/TDI waveform towards the SoC debug TAP, samples TDO during shift
// periods and hands the captured bits back on a second valid/ready interface.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   cmd_valid_i  command valid
//   cmd_ready_o  command ready (high only while idle)
//   cmd_type_i   0=TAP reset, 1=IR scan, 2=DR scan, 3=idle clocks
//   cmd_len_i    scan length or idle TCK count (clamped to MAX_LEN)
//   cmd_data_i   TDI bits, bit 0 shifted first
//   rsp_valid_o  response valid
//   rsp_ready_i  response ready
//   rsp_data_o   captured TDO bits, bit i = i-th shifted bit
//   tck_o        JTAG clock (rests low)
//   tms_o        JTAG mode select
//   tdi_o        JTAG data to TAP
//   tdo_i        JTAG data from TAP
//   trst_no      JTAG reset, active low
// -----------------------------------------------------------------------------
module jtag_tap_driver #(
   parameter int CLK_DIV = 4,
   parameter int MAX_LEN = 64,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic [1:0]         cmd_type_i,
   input  logic [LEN_W-1:0]   cmd_len_i,
   input  logic [MAX_LEN-1:0] cmd_data_i,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output logic [MAX_LEN-1:0] rsp_data_o,
   output logic               tck_o,
   output logic               tms_o,
   output logic               tdi_o,
   input  logic               tdo_i,
   output logic               trst_no
);

   // Period counter must hold the longest command: IR scan of MAX_LEN bits.
   localparam int PER_W = $clog2(MAX_LEN + 7);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   localparam logic [1:0] CMD_RESET = 2'd0;
   localparam logic [1:0] CMD_IR    = 2'd1;
   localparam logic [1:0] CMD_DR    = 2'd2;
   localparam logic [1:0] CMD_IDLE  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Number of TCK periods before the first shift period.
   function automatic logic [PER_W-1:0] prefix_len(input logic [1:0] typ);
      if (typ == CMD_IR) begin
         prefix_len = PER_W'(4);
      end else begin
         prefix_len = PER_W'(3);
      end
   endfunction

   // Total TCK periods emitted for a command.
   function automatic logic [PER_W-1:0] total_periods(input logic [1:0]       typ,
                                                      input logic [LEN_W-1:0] len);
      case (typ)
         CMD_RESET:      total_periods = PER_W'(6);
         CMD_IR, CMD_DR: total_periods = prefix_len(typ) + PER_W'(len) + PER_W'(2);
         CMD_IDLE:       total_periods = PER_W'(len);
         default:        total_periods = PER_W'(0);
      endcase
   endfunction

   // Pin values {trst_n, tms, tdi} for TCK period k of a command. Any k at or
   // beyond the end of the command yields the resting values.
   function automatic logic [2:0] period_ctl(input logic [1:0]         typ,
                                             input logic [LEN_W-1:0]   len,
                                             input logic [MAX_LEN-1:0] data,
                                             input logic [PER_W-1:0]   k);
      logic [PER_W-1:0] pre;
      logic [PER_W-1:0] n;
      logic [PER_W-1:0] sidx;
      logic             trst_n;
      logic             tms;
      logic             tdi;
      pre    = prefix_len(typ);
      n      = PER_W'(len);
      sidx   = k - pre;
      trst_n = 1'b1;
      tms    = 1'b0;
      tdi    = 1'b0;
      if (k < total_periods(typ, len)) begin
         case (typ)
            CMD_RESET: begin
               tms    = (k < PER_W'(5));
               trst_n = (k >= PER_W'(3));
            end
            CMD_IR, CMD_DR: begin
               if (k < pre) begin
                  // Select-DR, [Select-IR,] Capture, Shift. With no bits to
                  // shift the last step goes Capture->Exit1 instead.
                  if (k == PER_W'(0)) begin
                     tms = 1'b1;
                  end else if ((typ == CMD_IR) && (k == PER_W'(1))) begin
                     tms = 1'b1;
                  end else if ((k == pre - PER_W'(1)) && (n == PER_W'(0))) begin
                     tms = 1'b1;
                  end else begin
                     tms = 1'b0;
                  end
               end else if (k < pre + n) begin
                  // Last shift period also moves Shift->Exit1.
                  tms = (sidx == n - PER_W'(1));
                  for (int b = 0; b < MAX_LEN; b++) begin
                     if (sidx == PER_W'(b)) begin
                        tdi = data[b];
                     end
                  end
               end else if (k == pre + n) begin
                  tms = 1'b1;   // Exit1 -> Update
               end else begin
                  tms = 1'b0;   // Update -> Run-Test/Idle
               end
            end
            CMD_IDLE: begin
               tms = 1'b0;
            end
            default: begin
               tms = 1'b0;
            end
         endcase
      end
      return {trst_n, tms, tdi};
   endfunction

   state_t               state_q, state_d;
   logic [1:0]           typ_q, typ_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic [MAX_LEN-1:0]   data_q, data_d;
   logic [MAX_LEN-1:0]   cap_q, cap_d;
   logic [PER_W-1:0]     per_q, per_d;
   logic [PER_W-1:0]     tot_q, tot_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic                 tck_q, tck_d;
   logic                 tms_q, tms_d;
   logic                 tdi_q, tdi_d;
   logic                 trst_q, trst_d;
   logic                 cmd_ready_q, cmd_ready_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [MAX_LEN-1:0]   rsp_data_q, rsp_data_d;

   logic [LEN_W-1:0]     len_clamped;
   logic [PER_W-1:0]     cur_pre;
   logic [PER_W-1:0]     cur_sidx;
   logic                 cur_shift;

   assign len_clamped = (cmd_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len_i;

   // Decode whether the current TCK period is a shift period and its bit index.
   always_comb begin
      cur_pre = prefix_len(typ_q);
      if (((typ_q == CMD_IR) || (typ_q == CMD_DR)) &&
          (per_q >= cur_pre) && (per_q < cur_pre + PER_W'(len_q))) begin
         cur_shift = 1'b1;
         cur_sidx  = per_q - cur_pre;
      end else begin
         cur_shift = 1'b0;
         cur_sidx  = PER_W'(0);
      end
   end

   // Command sequencer: next-state, TCK timing, pin values and TDO capture.
   always_comb begin
      state_d     = state_q;
      typ_d       = typ_q;
      len_d       = len_q;
      data_d      = data_q;
      cap_d       = cap_q;
      per_d       = per_q;
      tot_d       = tot_q;
      div_d       = div_q;
      tck_d       = tck_q;
      tms_d       = tms_q;
      tdi_d       = tdi_q;
      trst_d      = trst_q;
      cmd_ready_d = cmd_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i && cmd_ready_q) begin
               state_d     = ST_RUN;
               cmd_ready_d = 1'b0;
               typ_d       = cmd_type_i;
               len_d       = len_clamped;
               data_d      = cmd_data_i;
               cap_d       = {MAX_LEN{1'b0}};
               per_d       = PER_W'(0);
               div_d       = DIV_W'(0);
               tck_d       = 1'b0;
               tot_d       = total_periods(cmd_type_i, len_clamped);
               {trst_d, tms_d, tdi_d} =
                  period_ctl(cmd_type_i, len_clamped, cmd_data_i, PER_W'(0));
            end else begin
               cmd_ready_d = 1'b1;
               trst_d      = 1'b1;
            end
         end

         ST_RUN: begin
            if (per_q == tot_q) begin
               // One cycle after the last high phase: publish the capture.
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_data_d  = cap_q;
            end else if (div_q == DIV_LAST) begin
               div_d = DIV_W'(0);
               if (tck_q == 1'b0) begin
                  tck_d = 1'b1;
               end else begin
                  // End of high phase: sample TDO, then start the next period
                  // with fresh TMS/TDI on its first low cycle.
                  tck_d = 1'b0;
                  per_d = per_q + PER_W'(1);
                  {trst_d, tms_d, tdi_d} =
                     period_ctl(typ_q, len_q, data_q, per_q + PER_W'(1));
                  if (cur_shift) begin
                     for (int b = 0; b < MAX_LEN; b++) begin
                        if (cur_sidx == PER_W'(b)) begin
                           cap_d[b] = tdo_i;
                        end
                     end
                  end else begin
                     cap_d = cap_q;
                  end
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end

         ST_RESP: begin
            if (rsp_ready_i) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
            end else begin
               rsp_valid_d = 1'b1;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            cmd_ready_d = 1'b1;
            rsp_valid_d = 1'b0;
            tck_d       = 1'b0;
            tms_d       = 1'b0;
            tdi_d       = 1'b0;
         end
      endcase
   end

   // State and output registers; reset forces all pins to their safe values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         typ_q       <= 2'd0;
         len_q       <= {LEN_W{1'b0}};
         data_q      <= {MAX_LEN{1'b0}};
         cap_q       <= {MAX_LEN{1'b0}};
         per_q       <= {PER_W{1'b0}};
         tot_q       <= {PER_W{1'b0}};
         div_q       <= {DIV_W{1'b0}};
         tck_q       <= 1'b0;
         tms_q       <= 1'b0;
         tdi_q       <= 1'b0;
         trst_q      <= 1'b0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= {MAX_LEN{1'b0}};
      end else begin
         state_q     <= state_d;
         typ_q       <= typ_d;
         len_q       <= len_d;
         data_q      <= data_d;
         cap_q       <= cap_d;
         per_q       <= per_d;
         tot_q       <= tot_d;
         div_q       <= div_d;
         tck_q       <= tck_d;
         tms_q       <= tms_d;
         tdi_q       <= tdi_d;
         trst_q      <= trst_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign cmd_ready_o = cmd_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign tck_o       = tck_q;
   assign tms_o       = tms_q;
   assign tdi_o       = tdi_q;
   assign trst_no     = trst_q;

endmodule

// File: tb/tb_jtag_tap_driver.sv
// -----------------------------------------------------------------------------
// tb_jtag_tap_driver
//
// Directed plus randomized bench for jtag_tap_driver. Pin activity is logged
// on every TCK rising edge and compared with a sequence model built from the
// JTAG state-walk rules for each command type.
// -----------------------------------------------------------------------------
module tb_jtag_tap_driver;

   localparam int CLK_DIV = 4;
   localparam int MAX_LEN = 64;
   localparam int LEN_W   = 7;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               cmd_valid;
   logic               cmd_ready;
   logic [1:0]         cmd_type;
   logic [LEN_W-1:0]   cmd_len;
   logic [MAX_LEN-1:0] cmd_data;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [MAX_LEN-1:0] rsp_data;
   logic               tck;
   logic               tms;
   logic               tdi;
   logic               tdo;
   logic               trst_n;

   int   tdo_mode = 0;       // 0: loop TDI back, 1: constant 1, 2: random
   logic tdo_rand = 1'b0;

   int checks = 0;
   int errors = 0;

   logic tms_log[$];
   logic tdi_log[$];
   logic trst_log[$];
   logic tdo_log[$];

   bit exp_tms[$];
   bit exp_tdi[$];
   bit exp_trst[$];
   int exp_pre;

   int   viol = 0;
   logic prev_tms = 1'b0;
   logic prev_tdi = 1'b0;

   always #5 clk = ~clk;

   assign tdo = (tdo_mode == 0) ? tdi : ((tdo_mode == 1) ? 1'b1 : tdo_rand);

   jtag_tap_driver #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_type_i(cmd_type), .cmd_len_i(cmd_len), .cmd_data_i(cmd_data),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
      .tck_o(tck), .tms_o(tms), .tdi_o(tdi), .tdo_i(tdo), .trst_no(trst_n)
   );

   // Pin log at every TCK rising edge.
   always @(posedge tck) begin
      tms_log.push_back(tms);
      tdi_log.push_back(tdi);
      trst_log.push_back(trst_n);
      tdo_log.push_back(tdo);
   end

   // Random TDO changes only while TCK is low.
   always @(negedge tck) begin
      logic [31:0] r;
      r = $urandom();
      tdo_rand = r[0];
   end

   // TMS/TDI must never move while TCK is high.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && tck === 1'b1 && (tms !== prev_tms || tdi !== prev_tdi)) begin
         viol = viol + 1;
      end
      prev_tms = tms;
      prev_tdi = tdi;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input bit t, input bit d, input bit r);
      exp_tms.push_back(t);
      exp_tdi.push_back(d);
      exp_trst.push_back(r);
   endtask

   // Expected per-period pins from the TAP state walk of each command.
   task automatic build_exp(input logic [1:0] typ, input int n, input logic [63:0] data);
      exp_tms.delete();
      exp_tdi.delete();
      exp_trst.delete();
      exp_pre = 0;
      case (typ)
         2'd0: begin
            for (int k = 0; k < 6; k++) push_exp(k < 5, 1'b0, k >= 3);
         end
         2'd1, 2'd2: begin
            push_exp(1'b1, 1'b0, 1'b1);                    // Select-DR
            if (typ == 2'd1) push_exp(1'b1, 1'b0, 1'b1);   // Select-IR
            push_exp(1'b0, 1'b0, 1'b1);                    // Capture
            push_exp(n == 0, 1'b0, 1'b1);                  // Shift, or Exit1
            exp_pre = exp_tms.size();
            for (int i = 0; i < n; i++) push_exp(i == n - 1, data[i], 1'b1);
            push_exp(1'b1, 1'b0, 1'b1);                    // Update
            push_exp(1'b0, 1'b0, 1'b1);                    // Run-Test/Idle
         end
         default: begin
            for (int k = 0; k < n; k++) push_exp(1'b0, 1'b0, 1'b1);
         end
      endcase
   endtask

   // Issue one command, check pins/latency/response, then complete the
   // response handshake after holding rsp_ready low for 'hold' cycles.
   task automatic do_cmd(input string name, input logic [1:0] typ, input int len,
                         input logic [63:0] data, input int mode, input int hold);
      int base, n, p, w, lat, cnt, idx;
      logic [127:0] o_tms, o_tdi, o_trst, e_tms, e_tdi, e_trst;
      logic [63:0]  e_rsp, hold_data;
      logic [31:0]  r;
      bit           stable;
      tdo_mode  = mode;
      base      = tms_log.size();
      cmd_type  = typ;
      cmd_len   = LEN_W'(len);
      cmd_data  = data;
      cmd_valid = 1'b1;
      w = 0;
      while (cmd_ready !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      check({name, ".ready"}, 128'(cmd_ready), 128'(1));
      @(posedge clk);
      lat = 0;
      while (lat < 2000) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (lat == 1) cmd_valid = 1'b0;
         if (rsp_valid === 1'b1) break;
      end

      n = (len > MAX_LEN) ? MAX_LEN : len;
      build_exp(typ, n, data);
      p = exp_tms.size();
      check({name, ".latency"}, 128'(lat), 128'(2 * CLK_DIV * p + 1));
      cnt = tms_log.size() - base;
      check({name, ".tck_count"}, 128'(cnt), 128'(p));
      o_tms = '0; o_tdi = '0; o_trst = '0; e_tms = '0; e_tdi = '0; e_trst = '0;
      for (int k = 0; k < cnt && k < 128; k++) begin
         o_tms[k]  = tms_log[base + k];
         o_tdi[k]  = tdi_log[base + k];
         o_trst[k] = trst_log[base + k];
      end
      for (int k = 0; k < p; k++) begin
         e_tms[k]  = exp_tms[k];
         e_tdi[k]  = exp_tdi[k];
         e_trst[k] = exp_trst[k];
      end
      check({name, ".tms"}, o_tms, e_tms);
      check({name, ".tdi"}, o_tdi, e_tdi);
      check({name, ".trst"}, o_trst, e_trst);

      e_rsp = '0;
      if (typ == 2'd1 || typ == 2'd2) begin
         for (int i = 0; i < n; i++) begin
            if (mode == 0) begin
               e_rsp[i] = data[i];
            end else if (mode == 1) begin
               e_rsp[i] = 1'b1;
            end else begin
               idx = base + exp_pre + i;
               e_rsp[i] = (idx < tdo_log.size()) ? tdo_log[idx] : 1'b0;
            end
         end
      end
      check({name, ".rsp_data"}, 128'(rsp_data), 128'(e_rsp));

      if (hold > 0) begin
         hold_data = rsp_data;
         stable    = 1'b1;
         r         = $urandom();
         cmd_type  = r[1:0];
         cmd_len   = r[8:2];
         cmd_data  = {$urandom(), $urandom()};
         cmd_valid = 1'b1;
         for (int j = 0; j < hold; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (!(rsp_valid === 1'b1 && rsp_data === hold_data && cmd_ready === 1'b0)) stable = 1'b0;
         end
         check({name, ".hold_stable"}, 128'(stable), 128'(1));
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      check({name, ".post_hs"}, 128'({rsp_valid, cmd_ready}), 128'(2'b01));
   endtask

   initial begin
      logic [63:0] d;
      logic [31:0] r;
      int w;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_type  = 2'd0;
      cmd_len   = '0;
      cmd_data  = '0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset.cmd_ready", 128'(cmd_ready), 128'(1));
      check("reset.rsp_valid", 128'(rsp_valid), 128'(0));
      check("reset.rsp_data", 128'(rsp_data), 128'(0));
      check("reset.pins", 128'({tck, tms, tdi, trst_n}), 128'(4'b0000));
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("reset.trst_release", 128'(trst_n), 128'(1));

      do_cmd("tap_reset", 2'd0, 0, 64'h0, 1, 0);
      do_cmd("dr8_a5", 2'd2, 8, 64'hA5, 0, 0);
      do_cmd("ir5_11", 2'd1, 5, 64'h11, 1, 0);
      d = {$urandom(), $urandom()};
      do_cmd("dr12_hold", 2'd2, 12, d, 2, 20);
      do_cmd("idle0", 2'd3, 0, 64'h0, 0, 0);
      do_cmd("idle3", 2'd3, 3, 64'h0, 0, 0);
      do_cmd("dr0", 2'd2, 0, 64'hFF, 1, 0);
      do_cmd("ir0", 2'd1, 0, 64'hFF, 1, 0);
      d = {$urandom(), $urandom()};
      do_cmd("dr64", 2'd2, 64, d, 0, 1);
      d = {$urandom(), $urandom()};
      do_cmd("dr_clamp", 2'd2, 100, d, 0, 0);
      do_cmd("ir1", 2'd1, 1, 64'h1, 2, 0);

      for (int i = 0; i < 10; i++) begin
         r = $urandom();
         d = {$urandom(), $urandom()};
         do_cmd($sformatf("rnd%0d", i), r[1:0], $urandom_range(0, 70), d,
                $urandom_range(0, 2), $urandom_range(0, 3));
      end

      // Reset in the middle of shifting bit 4 of a 32-bit DR scan.
      d = {$urandom(), $urandom()};
      d[4] = 1'b1;
      tdo_mode  = 0;
      w         = tms_log.size() + 8;
      cmd_type  = 2'd2;
      cmd_len   = 7'd32;
      cmd_data  = d;
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int c = 0; c < 1000 && tms_log.size() < w; c++) @(negedge clk);
      #2;
      check("midrst.tck_high", 128'(tck), 128'(1));
      check("midrst.tdi_bit4", 128'(tdi), 128'(1));
      rst_n = 1'b0;
      #1;
      check("midrst.pins", 128'({tck, tms, tdi, trst_n}), 128'(4'b0000));
      check("midrst.rsp_valid", 128'(rsp_valid), 128'(0));
      check("midrst.cmd_ready", 128'(cmd_ready), 128'(1));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst.after", 128'({cmd_ready, trst_n, rsp_valid}), 128'(3'b110));

      do_cmd("tap_reset2", 2'd0, 0, 64'h0, 2, 0);
      d = {$urandom(), $urandom()};
      do_cmd("dr20", 2'd2, 20, d, 0, 2);

      check("tms_tdi_change_while_tck_high", 128'(viol), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/jtag_tap_driver.md
Name: jtag_tap_driver

Overview:
- FPGA-side JTAG initiator that drives TCK/TMS/TDI into the SoC debug TAP pads and samples TDO.
- Lets on-board logic (UART bridge, self-test sequencer) access the debug TAP without an external probe.
- Takes high-level commands (TAP reset, IR scan, DR scan, idle clocks) over a valid/ready interface.
- Returns captured TDO bits over a second valid/ready interface.

Parameters:
- CLK_DIV, 4: clk_i cycles per TCK half-period; legal range is 1 or more.
- MAX_LEN, 64: maximum scan length in bits; LEN_W = $clog2(MAX_LEN+1).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command ready.
- cmd_type_i  in  2  command type: 0=TAP reset, 1=IR scan, 2=DR scan, 3=idle clocks.
- cmd_len_i  in  LEN_W  scan length, or idle TCK count.
- cmd_data_i  in  MAX_LEN  TDI bits, LSB shifted first.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_data_o  out  MAX_LEN  captured TDO bits; bit i is the i-th shifted bit.
- tck_o  out  1  JTAG clock.
- tms_o  out  1  JTAG mode select.
- tdi_o  out  1  JTAG data to TAP.
- tdo_i  in  1  JTAG data from TAP.
- trst_no  out  1  JTAG reset, active low.

Behaviour:
- Reset values: cmd_ready_o=1, rsp_valid_o=0, rsp_data_o=0, tck_o=0, tms_o=0, tdi_o=0, trst_no=0.
- trst_no deasserts on the first clk_i edge after reset release.
- Single clock domain. The reset is asynchronous and active-low (rst_ni), with synchronous deassertion handled upstream.
- TCK period: CLK_DIV cycles low, then CLK_DIV cycles high. tck_o rests low between commands.
- tms_o and tdi_o change only on the first cycle of a low phase.
- tdo_i is sampled on the last cycle of the high phase.
- States: IDLE, RUN, RESP.
  - IDLE: cmd_ready_o=1. On cmd_valid_i&cmd_ready_o, latch type, len and data, clear the capture register, and go to RUN.
  - RUN: cmd_ready_o=0. Emits the TMS/TDI sequence below, one entry per TCK period. After the final high phase completes, rsp_data_o is loaded and the block goes to RESP.
  - RESP: rsp_valid_o=1 and holds with data stable until rsp_ready_i. On the handshake cycle, go to IDLE. A new command is accepted only after the next edge.
- The TAP is assumed in Run-Test/Idle at command start and is always left in Run-Test/Idle. The driver guarantees this after any reset command.
- TAP reset (type 0): TMS=1,1,1,1,1,0 (6 TCK). trst_no=0 during the first 3 TCK periods. rsp_data=0.
- DR scan (type 2), N=len:
  - Prefix TMS=1,0,0 (Select-DR, Capture-DR, Shift-DR).
  - Then N shift periods with TDI=data[i]. TMS=0 except the last shift period, where TMS=1.
  - Then TMS=1,0 (Update, Idle). Total N+5 TCK.
- IR scan (type 1): prefix TMS=1,1,0,0, then as DR. Total N+6 TCK.
- TDO capture: in shift period i, the high-phase sample is stored at rsp_data[i]. Bits N and above are 0.
- tdi_o=0 outside shift periods.
- Scan with len 0: the prefix goes Capture→Exit1 directly, so the prefix's last TMS becomes 1. Then TMS=1,0 follow. rsp_data=0.
  - DR len 0 uses TMS=1,0,1,1,0 (5 TCK).
  - IR len 0 uses TMS=1,1,0,1,1,0 (6 TCK).
- len > MAX_LEN: clamped to MAX_LEN.
- Idle (type 3): N periods with TMS=0 and TDI=0. N=0 produces no TCK; go straight to RESP on the next cycle.
- Latency: rsp_valid_o rises 2*CLK_DIV*P+1 cycles after the command handshake edge, where P is the TCK period count.
- cmd_* inputs are ignored while not in IDLE.
- Reset mid-command: all outputs return to reset values immediately; tck_o drops low asynchronously.
  - The TAP state is then undefined; software must issue a TAP reset command.

Test Plan:
- Reset, then TAP reset command (CLK_DIV=4) → exactly 6 tck_o rising edges with TMS 1,1,1,1,1,0. trst_no low for the first 3 periods. rsp_valid at handshake+49 with rsp_data=0.
- DR scan len=8, data=0xA5, tdo_i looped from tdi_o → 13 TCK edges. TMS pattern 1,0,0,0000000,1,1,0. rsp_data=0x00…A5. rsp_valid at handshake+105.
- IR scan len=5, data=0x11, tdo_i tied 1 → 11 TCK edges with TMS prefix 1,1,0,0. rsp_data=0x1F.
- rsp_ready_i held low 20 cycles with cmd_valid_i high → rsp_data stable and cmd_ready_o=0 throughout. Next command accepted only after the handshake.
- Idle len=0 then idle len=3 → no TCK, rsp_valid after 1 cycle; then 3 TCK with TMS=0.
- rst_ni pulsed low mid DR scan (bit 4 of 32) → tck_o, tms_o, tdi_o and rsp_valid_o go 0 immediately and trst_no goes 0. After release, cmd_ready_o=1.
